// File: rtl/simple_module_pkg.sv
// -----------------------------------------------------------------------------
// simple_module_pkg
// Shared definitions for the up/down accumulating counter.
//   DEFAULT_WIDTH : default bit width of the step, the count register and the
//                   count output.
//   count_t       : count word at the default width.
// -----------------------------------------------------------------------------
package simple_module_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : simple_module_pkg

// File: rtl/simple_module_if.sv
// -----------------------------------------------------------------------------
// simple_module_if
// Groups the counter's data signals. The master drives direction and step;
// the slave (the counter) returns the registered count.
//   upDown : 1 = add addVal, 0 = subtract addVal
//   addVal : unsigned step, WIDTH bits
//   count  : registered counter value, WIDTH bits
// -----------------------------------------------------------------------------
interface simple_module_if
    import simple_module_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             upDown;
    logic [WIDTH-1:0] addVal;
    logic [WIDTH-1:0] count;

    modport master (
        output upDown,
        output addVal,
        input  count
    );

    modport slave (
        input  upDown,
        input  addVal,
        output count
    );

endinterface : simple_module_if

// File: rtl/simple_module_addsub.sv
// -----------------------------------------------------------------------------
// simple_module_addsub
// Combinational WIDTH-bit adder/subtractor, modulo 2^WIDTH.
//   a_i  : first operand (current count)
//   b_i  : second operand (step)
//   up_i : 1 = a_i + b_i, 0 = a_i - b_i
//   y_o  : result, carry/borrow discarded
// -----------------------------------------------------------------------------
module simple_module_addsub
    import simple_module_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] y_o
);

    // The WIDTH-bit result truncates the carry/borrow, which gives the
    // wrap-around behaviour directly.
    assign y_o = up_i ? (a_i + b_i) : (a_i - b_i);

endmodule : simple_module_addsub

// File: rtl/simple_module.sv
// -----------------------------------------------------------------------------
// simple_module
// Up/down accumulating counter. Every rising clk edge out of reset the count
// register moves by addVal in the direction selected by upDown, wrapping
// modulo 2^WIDTH. The count output comes straight from the register.
//   clk     : clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset, clears the count
//   bus     : slave side of simple_module_if (upDown, addVal in; count out)
// -----------------------------------------------------------------------------
module simple_module
    import simple_module_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            reset_n,
    simple_module_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] sum;

    simple_module_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i  (count_q),
        .b_i  (bus.addVal),
        .up_i (bus.upDown),
        .y_o  (sum)
    );

    // Reset mux sits in front of the register so the reset is sampled on
    // the clock edge only.
    always_comb begin
        // NOTE: assign the default first so every path drives count_d and
        // no latch is inferred.
        count_d = sum;
        if (!reset_n) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        count_q <= count_d;
    end

    assign bus.count = count_q;

endmodule : simple_module

// File: tb/tb_simple_module.sv
// -----------------------------------------------------------------------------
// tb_simple_module
// Directed bench for the up/down accumulating counter at WIDTH = 8.
// Inputs change just after the falling edge; count is sampled on the falling
// edge, half a period after the rising edge that updated it.
// -----------------------------------------------------------------------------
module tb_simple_module;
    import simple_module_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    int     errors = 0;
    int     checks = 0;
    count_t exp_cnt;

    simple_module_if #(.WIDTH(8)) bus ();

    simple_module #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One reset cycle, then release with the next stimulus already applied.
    task automatic apply_reset(input logic up, input count_t step);
        reset_n    = 1'b0;
        bus.upDown = 1'b1;
        bus.addVal = 8'd77;
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd0) begin
            errors++;
            $display("FAIL apply_reset: count=%0d expected=0", bus.count);
        end
        reset_n    = 1'b1;
        bus.upDown = up;
        bus.addVal = step;
        exp_cnt    = 8'd0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.upDown = 1'b1;
        bus.addVal = 8'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.count !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: count=%0d expected=0", i, bus.count);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd5) begin
            errors++;
            $display("FAIL reset_release: count=%0d expected=5", bus.count);
        end
    endtask

    task automatic test_down_wrap();
        apply_reset(1'b0, 8'd1);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) bus.addVal = 8'd2;
            exp_cnt = exp_cnt - bus.addVal;
            @(negedge clk);
            checks++;
            if (bus.count !== exp_cnt) begin
                errors++;
                $display("FAIL down_wrap[%0d]: count=%0d expected=%0d", i, bus.count, exp_cnt);
            end
        end
        checks++;
        if (bus.count !== 8'd244) begin
            errors++;
            $display("FAIL down_wrap_final: count=%0d expected=244", bus.count);
        end
    endtask

    // Continues from 244 left by test_down_wrap.
    task automatic test_up_wrap();
        bus.upDown = 1'b1;
        bus.addVal = 8'd1;
        repeat (7) @(negedge clk);
        checks++;
        if (bus.count !== 8'd251) begin
            errors++;
            $display("FAIL up_251: count=%0d expected=251", bus.count);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (bus.count !== 8'd2) begin
            errors++;
            $display("FAIL up_wrap_2: count=%0d expected=2", bus.count);
        end
    endtask

    task automatic test_hold();
        apply_reset(1'b1, 8'd100);
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd100) begin
            errors++;
            $display("FAIL hold_setup: count=%0d expected=100", bus.count);
        end
        bus.addVal = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bus.upDown = i[0];
            @(negedge clk);
            checks++;
            if (bus.count !== 8'd100) begin
                errors++;
                $display("FAIL hold[%0d]: count=%0d expected=100", i, bus.count);
            end
        end
    endtask

    task automatic test_max_step();
        apply_reset(1'b1, 8'd255);
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd255) begin
            errors++;
            $display("FAIL max_up_1: count=%0d expected=255", bus.count);
        end
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd254) begin
            errors++;
            $display("FAIL max_up_2: count=%0d expected=254", bus.count);
        end
        bus.upDown = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd255) begin
            errors++;
            $display("FAIL max_down: count=%0d expected=255", bus.count);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset(1'b1, 8'd90);
        @(negedge clk);
        bus.addVal = 8'd3;
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd93) begin
            errors++;
            $display("FAIL mid_pre: count=%0d expected=93", bus.count);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d expected=0", bus.count);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.count !== 8'(3 * i)) begin
                errors++;
                $display("FAIL mid_resume[%0d]: count=%0d expected=%0d", i, bus.count, 3 * i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_down_wrap();
        test_up_wrap();
        test_hold();
        test_max_step();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_simple_module
